branch_ctrl: RTL



---
 rtl/branch_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves RV32I B-type branches, issues PC redirects, then flushes the pipeline.
module branch_ctrl #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            resolve_valid,
  output logic            br_taken,
  output logic            illegal,
  output logic            misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush,
  output logic            busy,
  output logic [CNT_W-1:0] taken_cnt
);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;
  state_t state;
  logic [FW-1:0] fcnt;
  logic [XLEN-1:0] tgt_q;
  logic eq, lts, ltu, cond, ill, mis;
  logic [XLEN-1:0] target;
  // Conditions are evaluated from the live inputs so the result is registered at the accept edge.
  always_comb begin
    eq = rdata1 == rdata2;
    lts = $signed(rdata1) < $signed(rdata2);
    ltu = rdata1 < rdata2;
    ill = funct3[2:1] == 2'b01;
    cond = funct3[2] ? ((funct3[1] ? ltu : lts) ^ funct3[0]) : (eq ^ funct3[0]);
    target = pc + imm;
    mis = cond && !ill && target[1:0] != 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      br_ready <= 1'b1;
      resolve_valid <= 1'b0;
      br_taken <= 1'b0;
      illegal <= 1'b0;
      misalign <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      flush <= 1'b0;
      busy <= 1'b0;
      taken_cnt <= '0;
      fcnt <= '0;
      tgt_q <= '0;
    end else begin
      resolve_valid <= 1'b0;
      illegal <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: if (br_valid && opcode == 7'b1100011) begin
          state <= EVAL;
          br_ready <= 1'b0;
          busy <= 1'b1;
          resolve_valid <= !ill;
          br_taken <= cond && !ill;
          illegal <= ill;
          misalign <= mis;
          tgt_q <= target;
        end
        EVAL: if (br_taken && !misalign) begin
          state <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc <= tgt_q;
        end else begin
          state <= IDLE;
          br_ready <= 1'b1;
          busy <= 1'b0;
        end
        REDIRECT: if (redirect_ack) begin
          redirect_valid <= 1'b0;
          taken_cnt <= &taken_cnt ? taken_cnt : taken_cnt + 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state <= FLUSH;
            flush <= 1'b1;
            fcnt <= FW'(FLUSH_CYCLES);
          end else begin
            state <= IDLE;
            br_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
        FLUSH: if (fcnt <= 1) begin
          state <= IDLE;
          flush <= 1'b0;
          br_ready <= 1'b1;
          busy <= 1'b0;
        end else fcnt <= fcnt - 1'b1;
      endcase
    end
endmodule
